rgb_serializer: RTL and testbench

Parallel-to-serial pixel transmitter: accepts one 24-bit pixel (8-bit red, green, blue) per handshake and shifts it out one bit per clock on a single serial line, qualified by `output_valid`. It is the transmit end of the team's serial RGB link, driving the receiver that rebuilds pixels from `shift_in`/`input_valid` on the DE10-Lite ↔ Raspberry Pi accelerator path. Bit order is OpenCV BGR, MSB first. A one-entry holding register lets pixels stream back-to-back with no idle cycles.

---
 rtl/rgb_serializer.sv | 142 ++++++++++++++
 tb/tb_rgb_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_serializer.sv
// Parallel-to-serial RGB pixel transmitter: 24-bit pixel sent as BGR, MSB first, with a one-entry hold register.
// Define RGB_SERIALIZER_REALIGN_EN to insert a one-cycle GAP (output_valid low) after every pixel.
module rgb_serializer (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       pixel_valid,
   output logic       pixel_ready,
   output logic       shift_out,
   output logic       output_valid,
   output logic       tx_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t      r_state;
   logic [23:0] r_sr;
   logic [4:0]  r_bitcnt;
   logic [23:0] r_hold;
   logic        r_hold_full;

   state_t      w_state_nxt;
   logic [23:0] w_sr_nxt;
   logic [4:0]  w_bitcnt_nxt;
   logic [23:0] w_hold_nxt;
   logic        w_hold_full_nxt;

   logic        w_accept;
   logic        w_last;
   logic [23:0] w_pixel;

   // Ready comes straight from the hold flag flop, so there is no path from pixel_valid.
   assign pixel_ready = !r_hold_full;
   assign w_accept    = pixel_valid && !r_hold_full;
   assign w_last      = (r_bitcnt == 5'd23);
   assign w_pixel     = {blue, green, red};

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sr and hold are reset as well so an aborted pixel can never resurface after reset.
      if (reset) begin
         r_state     <= S_IDLE;
         r_sr        <= '0;
         r_bitcnt    <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sr        <= w_sr_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
      end
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path through the case can infer a latch.
      w_state_nxt     = r_state;
      w_sr_nxt        = r_sr;
      w_bitcnt_nxt    = r_bitcnt;
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_sr_nxt     = w_pixel;
               w_bitcnt_nxt = '0;
               w_state_nxt  = S_SHIFT;
            end
         end

         S_SHIFT: begin
            w_sr_nxt     = {r_sr[22:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt + 5'd1;
            if (!w_last) begin
               if (w_accept) begin
                  w_hold_nxt      = w_pixel;
                  w_hold_full_nxt = 1'b1;
               end
            end else begin
               w_bitcnt_nxt = '0;
`ifdef RGB_SERIALIZER_REALIGN_EN
               // Every pixel is followed by GAP; a pixel arriving on the last bit waits in hold.
               w_state_nxt = S_GAP;
               if (w_accept) begin
                  w_hold_nxt      = w_pixel;
                  w_hold_full_nxt = 1'b1;
               end
`else
               if (r_hold_full) begin
                  w_sr_nxt        = r_hold;
                  w_hold_full_nxt = 1'b0;
               end else if (w_accept) begin
                  w_sr_nxt = w_pixel;
               end else begin
                  w_state_nxt = S_IDLE;
               end
`endif
            end
         end

`ifdef RGB_SERIALIZER_REALIGN_EN
         S_GAP: begin
            w_bitcnt_nxt = '0;
            if (r_hold_full) begin
               w_sr_nxt        = r_hold;
               w_hold_full_nxt = 1'b0;
               w_state_nxt     = S_SHIFT;
            end else if (w_accept) begin
               w_sr_nxt    = w_pixel;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`endif

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs decode from state flops only, so reset forces them low without waiting for a clock.
   always_comb begin
      output_valid = 1'b0;
      shift_out    = 1'b0;
      tx_done      = 1'b0;
      if (r_state == S_SHIFT) begin
         output_valid = 1'b1;
         shift_out    = r_sr[23];
         tx_done      = w_last;
      end
   end

endmodule

// File: tb/tb_rgb_serializer.sv
// Self-checking bench for rgb_serializer: directed timing tasks plus a receiver-model scoreboard.
`timescale 1ns/1ps
module tb_rgb_serializer;

   localparam int LOG_N = 8192;
`ifdef RGB_SERIALIZER_REALIGN_EN
   localparam bit REALIGN = 1'b1;
`else
   localparam bit REALIGN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] red = '0;
   logic [7:0] green = '0;
   logic [7:0] blue = '0;
   logic       pixel_valid = 1'b0;
   logic       pixel_ready;
   logic       shift_out;
   logic       output_valid;
   logic       tx_done;

   int n_chk  = 0;
   int n_pass = 0;
   int rx_pix = 0;
   int cyc    = 0;

   logic [23:0] sb_q[$];
   logic        log_v [0:LOG_N-1];
   logic        log_s [0:LOG_N-1];
   logic        log_d [0:LOG_N-1];
   logic        log_r [0:LOG_N-1];

   rgb_serializer dut (
      .clk          (clk),
      .reset        (reset),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .shift_out    (shift_out),
      .output_valid (output_valid),
      .tx_done      (tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one pixel; returns the cycle count just after the accepting edge.
   task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, output int acc);
      red = r;
      green = g;
      blue = b;
      pixel_valid = 1'b1;
      acc = -1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (pixel_ready) begin
            sb_q.push_back({b, g, r});
            @(posedge clk);
            #1;
            acc = cyc;
            break;
         end
      end
      pixel_valid = 1'b0;
      n_chk++;
      if (acc < 0) begin
         $display("FAIL send_timeout: pixel %02h%02h%02h never accepted", b, g, r);
         @(posedge clk);
         #1;
      end else n_pass++;
   endtask

   // Receiver model: frames 24 valid bits, compares against the scoreboard, logs every cycle.
   task automatic monitor();
      logic [23:0] rx_sr;
      logic [23:0] exp_pix;
      int          rx_cnt;
      rx_sr  = '0;
      rx_cnt = 0;
      forever begin
         @(negedge clk);
         if (cyc < LOG_N) begin
            log_v[cyc] = output_valid;
            log_s[cyc] = shift_out;
            log_d[cyc] = tx_done;
            log_r[cyc] = pixel_ready;
         end
         if (reset) begin
            rx_cnt = 0;
         end else if (output_valid) begin
            rx_sr = {rx_sr[22:0], shift_out};
            rx_cnt++;
            n_chk++;
            if (tx_done !== (rx_cnt == 24))
               $display("FAIL tx_done_pos: got %b at bit %0d", tx_done, rx_cnt);
            else n_pass++;
            if (rx_cnt == 24) begin
               rx_cnt = 0;
               rx_pix++;
               n_chk++;
               if (sb_q.size() == 0) begin
                  $display("FAIL rx_unexpected: got pixel %06h with empty scoreboard", rx_sr);
               end else begin
                  exp_pix = sb_q.pop_front();
                  if (rx_sr !== exp_pix)
                     $display("FAIL rx_pixel: got %06h expected %06h", rx_sr, exp_pix);
                  else n_pass++;
               end
            end
         end else begin
            n_chk++;
            if (rx_cnt != 0 || shift_out !== 1'b0 || tx_done !== 1'b0)
               $display("FAIL idle_line: bits_in_frame=%0d shift_out=%b tx_done=%b expected 0/0/0",
                        rx_cnt, shift_out, tx_done);
            else n_pass++;
            rx_cnt = 0;
         end
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({output_valid, shift_out, tx_done, pixel_ready} !== 4'b0001)
         $display("FAIL reset_outputs: v/s/d/rdy=%b%b%b%b expected 0001",
                  output_valid, shift_out, tx_done, pixel_ready);
      else n_pass++;
      reset = 1'b0;
      wait_cycles(2);
      n_chk++;
      if ({output_valid, pixel_ready} !== 2'b01)
         $display("FAIL post_reset_idle: v/rdy=%b%b expected 01", output_valid, pixel_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      int          a;
      logic [23:0] p;
      logic [2:0]  exp_vsd;
      p = 24'h563412;
      send(8'h12, 8'h34, 8'h56, a);
      wait_cycles(26);
      for (int c = 1; c <= 25; c++) begin
         int k;
         k = a + c - 1;
         exp_vsd = {c <= 24, (c <= 24) ? p[24 - c] : 1'b0, c == 24};
         n_chk++;
         if ({log_v[k], log_s[k], log_d[k]} !== exp_vsd)
            $display("FAIL single_cycle%0d: v/s/d=%b%b%b expected %b", c, log_v[k], log_s[k], log_d[k], exp_vsd);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int         a1, a2;
      logic [1:0] exp_vd;
      send(8'hFF, 8'h00, 8'h00, a1);
      send(8'h00, 8'hFF, 8'h00, a2);
      wait_cycles(52);
      n_chk++;
      if (a2 !== a1 + 1) $display("FAIL b2b_accept: second accept at +%0d expected +1", a2 - a1);
      else n_pass++;
      for (int c = 1; c <= 50; c++) begin
         int k;
         k = a1 + c - 1;
         if (REALIGN) exp_vd = {c <= 49 && c != 25, c == 24 || c == 49};
         else         exp_vd = {c <= 48,             c == 24 || c == 48};
         n_chk++;
         if ({log_v[k], log_d[k]} !== exp_vd)
            $display("FAIL b2b_cycle%0d: v/d=%b%b expected %b", c, log_v[k], log_d[k], exp_vd);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int a1, a2, a3;
      int exp_a3;
      send(8'h01, 8'h02, 8'h03, a1);
      send(8'h04, 8'h05, 8'h06, a2);
      send(8'h07, 8'h08, 8'h09, a3);
      exp_a3 = a1 + (REALIGN ? 26 : 25);
      n_chk++;
      if (a2 !== a1 + 1) $display("FAIL bp_second: accept at +%0d expected +1", a2 - a1);
      else n_pass++;
      n_chk++;
      if (a3 !== exp_a3) $display("FAIL bp_third: accept at +%0d expected +%0d", a3 - a1, exp_a3 - a1);
      else n_pass++;
      n_chk++;
      if ({log_r[a1], log_r[a1 + 1], log_r[a1 + 23], log_r[a1 + 24]} !== {3'b100, !REALIGN})
         $display("FAIL bp_ready: cycles 1/2/24/25 = %b%b%b%b expected %b%b",
                  log_r[a1], log_r[a1 + 1], log_r[a1 + 23], log_r[a1 + 24], 3'b100, !REALIGN);
      else n_pass++;
      wait_cycles(55);
   endtask

   task automatic test_bypass();
      int a1, a2;
      int first_bit, n_valid;
      send(8'h00, 8'hC3, 8'h3C, a1);
      wait_cycles(23);
      send(8'h11, 8'h22, 8'h80, a2);
      wait_cycles(28);
      n_chk++;
      if (a2 !== a1 + 24) $display("FAIL bypass_accept: at +%0d expected +24", a2 - a1);
      else n_pass++;
      first_bit = a1 + (REALIGN ? 25 : 24);
      n_chk++;
      if ({log_v[first_bit], log_s[first_bit]} !== 2'b11)
         $display("FAIL bypass_first_bit: v/s=%b%b expected 11", log_v[first_bit], log_s[first_bit]);
      else n_pass++;
      n_valid = 0;
      for (int c = 1; c <= 48; c++) n_valid += int'(log_v[a1 + c - 1]);
      n_chk++;
      if (n_valid !== (REALIGN ? 47 : 48))
         $display("FAIL bypass_stream: %0d valid cycles in 1..48 expected %0d", n_valid, REALIGN ? 47 : 48);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int a1, a2;
      int r0, n_valid;
      send(8'hAA, 8'hBB, 8'hCC, a1);
      send(8'hDD, 8'hEE, 8'hFF, a2);
      wait_cycles(8);
      n_chk++;
      if ({output_valid, pixel_ready} !== 2'b10)
         $display("FAIL mid_precond: v/rdy=%b%b expected 10", output_valid, pixel_ready);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if ({output_valid, shift_out, tx_done, pixel_ready} !== 4'b0001)
         $display("FAIL mid_reset_async: v/s/d/rdy=%b%b%b%b expected 0001",
                  output_valid, shift_out, tx_done, pixel_ready);
      else n_pass++;
      sb_q.delete();
      wait_cycles(3);
      reset = 1'b0;
      r0 = cyc;
      wait_cycles(30);
      n_valid = 0;
      for (int k = r0; k < cyc; k++) n_valid += int'(log_v[k]);
      n_chk++;
      if (n_valid !== 0 || pixel_ready !== 1'b1)
         $display("FAIL mid_reset_quiet: %0d valid cycles, rdy=%b expected 0 and 1", n_valid, pixel_ready);
      else n_pass++;
   endtask

   task automatic test_loopback();
      int a, start, gap;
      start = rx_pix;
      for (int i = 0; i < 100; i++) begin
         send(8'($urandom), 8'($urandom), 8'($urandom), a);
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
         wait_cycles(gap);
      end
      for (int t = 0; t < 300 && sb_q.size() != 0; t++) wait_cycles(1);
      wait_cycles(3);
      n_chk++;
      if (sb_q.size() != 0 || rx_pix - start != 100)
         $display("FAIL loopback_count: received %0d, %0d left in scoreboard, expected 100 and 0",
                  rx_pix - start, sb_q.size());
      else n_pass++;
   endtask

   initial begin
      fork
         monitor();
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog expired");
         end
      join_none
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_bypass();
      test_reset_mid();
      test_loopback();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
